reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 81 ++++++++
 tb/tb_reg_write_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester round-robin write arbiter over a 4-entry register bank
module reg_write_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [1:0]       ADDR0,
  input  logic [WIDTH-1:0] DATA0,
  input  logic             REQ1,
  input  logic [1:0]       ADDR1,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [1:0]       RADDR,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] RDATA,
  output logic             BUSY,
  output logic [7:0]       WCNT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR0  = 2'd1;
  localparam logic [1:0] WR1  = 2'd2;

  logic [1:0]       state;
  logic             pri;
  logic [1:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] bank [4];

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pri   <= 1'b0;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      WCNT  <= 8'd0;
      RDATA <= '0;
      waddr <= 2'd0;
      wdata <= '0;
      for (int i = 0; i < 4; i++) begin
        bank[i] <= '0;
      end
    end else begin
      // Read uses the pre-write bank contents when addresses collide.
      RDATA <= bank[RADDR];
      case (state)
        IDLE: begin
          if (REQ0 && (!REQ1 || !pri)) begin
            state <= WR0;
            GNT0  <= 1'b1;
            waddr <= ADDR0;
            wdata <= DATA0;
            pri   <= 1'b1;
          end else if (REQ1) begin
            state <= WR1;
            GNT1  <= 1'b1;
            waddr <= ADDR1;
            wdata <= DATA1;
            pri   <= 1'b0;
          end
        end
        WR0, WR1: begin
          bank[waddr] <= wdata;
          WCNT        <= WCNT + 8'd1;
          state       <= IDLE;
          GNT0        <= 1'b0;
          GNT1        <= 1'b0;
        end
        default: begin
          state <= IDLE;
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0, REQ1;
  logic [1:0] ADDR0, ADDR1, RADDR;
  logic [3:0] DATA0, DATA1;
  logic       GNT0, GNT1, BUSY;
  logic [3:0] RDATA;
  logic [7:0] WCNT;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1),
    .RADDR(RADDR),
    .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA), .BUSY(BUSY), .WCNT(WCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       r0;
    logic [1:0] a0;
    logic [3:0] d0;
    logic       r1;
    logic [1:0] a1;
    logic [3:0] d1;
    logic [1:0] ra;
    logic       eg0;
    logic       eg1;
    logic       eb;
    logic [3:0] erd;
    logic [7:0] ewc;
  } vec_t;

  typedef struct {
    logic       who;
    logic [1:0] addr;
    logic [3:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  function automatic vec_t mk(logic rst, logic r0, logic [1:0] a0, logic [3:0] d0,
                              logic r1, logic [1:0] a1, logic [3:0] d1, logic [1:0] ra,
                              logic eg0, logic eg1, logic eb, logic [3:0] erd, logic [7:0] ewc);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.ra = ra;
    v.eg0 = eg0; v.eg1 = eg1; v.eb = eb; v.erd = erd; v.ewc = ewc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] shadow [4];
  logic       m_pri;
  logic       m_busy;
  logic [7:0] m_wcnt;
  logic [3:0] exp_rd;
  wr_t        cur;
  wr_t        nw;
  logic       granted;

  initial begin
    RST = 1'b1; REQ0 = 0; REQ1 = 0; ADDR0 = 0; ADDR1 = 0; DATA0 = 0; DATA1 = 0; RADDR = 0;

    //             rst r0 a0 d0   r1 a1 d1   ra  g0 g1 bsy rd  wcnt
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 2, 5,  0, 0, 0,  2,  1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 0, 2, 5,  0, 0, 0,  2,  0, 0, 0, 0,  1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  2,  0, 0, 0, 5,  1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 1, 3,  2,  0, 1, 1, 5,  1));
    vecs.push_back(mk(0, 1, 0, 3,  1, 1, 10, 1,  0, 0, 0, 0,  2));
    vecs.push_back(mk(0, 1, 0, 3,  1, 1, 10, 1,  1, 0, 1, 3,  2));
    vecs.push_back(mk(0, 1, 0, 15, 1, 1, 10, 1,  0, 0, 0, 3,  3));
    vecs.push_back(mk(0, 1, 0, 15, 1, 1, 10, 1,  0, 1, 1, 3,  3));
    vecs.push_back(mk(0, 1, 0, 15, 1, 1, 10, 1,  0, 0, 0, 3,  4));
    vecs.push_back(mk(0, 1, 0, 15, 1, 1, 10, 1,  1, 0, 1, 10, 4));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 3,  5));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 15, 5));
    vecs.push_back(mk(0, 0, 0, 0,  1, 3, 12, 3,  0, 1, 1, 0,  5));
    vecs.push_back(mk(1, 0, 0, 0,  0, 3, 12, 3,  0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  3,  0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  2,  0, 0, 0, 0,  0));
    vecs.push_back(mk(1, 1, 3, 6,  0, 0, 0,  0,  0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 3, 6,  1, 2, 9,  3,  1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  3,  0, 0, 0, 0,  1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,  3,  0, 0, 0, 6,  1));

    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst;
      REQ0 = vecs[i].r0; ADDR0 = vecs[i].a0; DATA0 = vecs[i].d0;
      REQ1 = vecs[i].r1; ADDR1 = vecs[i].a1; DATA1 = vecs[i].d1;
      RADDR = vecs[i].ra;
      tick();
      chk("gnt0",  i, 32'(GNT0),  32'(vecs[i].eg0));
      chk("gnt1",  i, 32'(GNT1),  32'(vecs[i].eg1));
      chk("busy",  i, 32'(BUSY),  32'(vecs[i].eb));
      chk("rdata", i, 32'(RDATA), 32'(vecs[i].erd));
      chk("wcnt",  i, 32'(WCNT),  32'(vecs[i].ewc));
    end

    // Randomised run against a shadow bank; long enough to wrap WCNT.
    RST = 1'b1; REQ0 = 0; REQ1 = 0;
    tick();
    RST = 1'b0;
    for (int j = 0; j < 4; j++) shadow[j] = 4'd0;
    m_pri = 1'b0; m_busy = 1'b0; m_wcnt = 8'd0;
    cur.who = 0; cur.addr = 0; cur.data = 0;

    for (int c = 0; c < 700; c++) begin
      REQ0 = ($urandom_range(3) != 0); ADDR0 = 2'($urandom_range(3)); DATA0 = 4'($urandom_range(15));
      REQ1 = ($urandom_range(3) != 0); ADDR1 = 2'($urandom_range(3)); DATA1 = 4'($urandom_range(15));
      RADDR = 2'($urandom_range(3));
      exp_rd = shadow[RADDR];
      granted = 1'b0;
      if (m_busy) begin
        shadow[cur.addr] = cur.data;
        m_wcnt = m_wcnt + 8'd1;
        m_busy = 1'b0;
      end else if (REQ0 || REQ1) begin
        nw.who  = (REQ0 && (!REQ1 || !m_pri)) ? 1'b0 : 1'b1;
        nw.addr = nw.who ? ADDR1 : ADDR0;
        nw.data = nw.who ? DATA1 : DATA0;
        sb.push_back(nw);
        m_pri  = ~nw.who;
        m_busy = 1'b1;
        granted = 1'b1;
      end
      tick();
      chk("r_busy",  c, 32'(BUSY),  32'(m_busy));
      chk("r_rdata", c, 32'(RDATA), 32'(exp_rd));
      chk("r_wcnt",  c, 32'(WCNT),  32'(m_wcnt));
      chk("r_excl",  c, 32'(GNT0 && GNT1), 32'(0));
      if (GNT0 || GNT1) begin
        if (sb.size() == 0) begin
          chk("r_spurious_gnt", c, 32'(1), 32'(0));
        end else begin
          cur = sb.pop_front();
          chk("r_gnt1", c, 32'(GNT1), 32'(cur.who));
        end
      end else if (granted) begin
        chk("r_missing_gnt", c, 32'(0), 32'(1));
        void'(sb.pop_front());
      end
    end
    chk("r_sb_empty", 0, 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
